// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a 4-chip byte-wide asynchronous SRAM bank.
// Each 32-bit request becomes one SETUP/STROBE/HOLD cycle per enabled byte.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int WAIT_CYCLES  = 2,
  parameter bit FIXED_PRIO_A = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic [20:0] i_a_addr,
  input  logic [3:0]  i_a_be,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_ack,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [20:0] i_b_addr,
  input  logic [3:0]  i_b_be,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_ack,
  output logic [31:0] o_b_rdata,
  output logic [3:0]  o_sram_cs_n,
  output logic        o_sram_read_n,
  output logic        o_sram_write_n,
  output logic [20:0] o_sram_addr,
  output logic [7:0]  o_sram_data,
  output logic        o_sram_data_oe,
  input  logic [7:0]  i_sram_data,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  // {found, index} of the lowest set bit
  function automatic logic [2:0] first_set(input logic [3:0] mask);
    logic [2:0] res;
    casez (mask)
      4'b???1: res = 3'b100;
      4'b??10: res = 3'b101;
      4'b?100: res = 3'b110;
      4'b1000: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] above_mask(input logic [1:0] idx);
    logic [3:0] res;
    case (idx)
      2'd0:    res = 4'b1110;
      2'd1:    res = 4'b1100;
      2'd2:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] cs_decode(input logic [1:0] sel);
    logic [3:0] res;
    case (sel)
      2'd0:    res = 4'b1110;
      2'd1:    res = 4'b1101;
      2'd2:    res = 4'b1011;
      2'd3:    res = 4'b0111;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  state_t      state_r, state_s;
  logic        port_b_r, port_b_s;
  logic        we_r, we_s;
  logic [20:0] waddr_r, waddr_s;
  logic [3:0]  be_r, be_s;
  logic [31:0] wdata_r, wdata_s;
  logic [1:0]  idx_r, idx_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] rdbuf_r, rdbuf_s;
  logic        favour_b_r, favour_b_s;
  logic        pick_b_s;
  logic [2:0]  first_s, next_s;

  logic [3:0]  cs_n_r, cs_n_s;
  logic        rd_n_r, rd_n_s;
  logic        wr_n_r, wr_n_s;
  logic [20:0] addr_r, addr_s;
  logic [7:0]  dout_r, dout_s;
  logic        oe_r, oe_s;
  logic        a_ack_r, a_ack_s;
  logic        b_ack_r, b_ack_s;
  logic [31:0] a_rdata_r, a_rdata_s;
  logic [31:0] b_rdata_r, b_rdata_s;
  logic        busy_r, busy_s;

  // Next-state, latch and output decode
  always_comb begin
    state_s    = state_r;
    port_b_s   = port_b_r;
    we_s       = we_r;
    waddr_s    = waddr_r;
    be_s       = be_r;
    wdata_s    = wdata_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    rdbuf_s    = rdbuf_r;
    favour_b_s = favour_b_r;
    pick_b_s   = 1'b0;
    first_s    = 3'b000;
    next_s     = 3'b000;
    cs_n_s     = 4'hF;
    rd_n_s     = 1'b1;
    wr_n_s     = 1'b1;
    addr_s     = addr_r;
    dout_s     = dout_r;
    oe_s       = 1'b0;
    a_ack_s    = 1'b0;
    b_ack_s    = 1'b0;
    a_rdata_s  = a_rdata_r;
    b_rdata_s  = b_rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (i_a_req || i_b_req) begin
          pick_b_s   = i_b_req && (!i_a_req || (!FIXED_PRIO_A && favour_b_r));
          port_b_s   = pick_b_s;
          favour_b_s = !pick_b_s;
          if (pick_b_s) begin
            we_s    = i_b_we;
            waddr_s = i_b_addr;
            be_s    = i_b_be;
            wdata_s = i_b_wdata;
          end else begin
            we_s    = i_a_we;
            waddr_s = i_a_addr;
            be_s    = i_a_be;
            wdata_s = i_a_wdata;
          end
          rdbuf_s = 32'h0000_0000;
          first_s = first_set(be_s);
          idx_s   = first_s[1:0];
          if (first_s[2]) begin
            state_s = ST_SETUP;
          end else begin
            state_s = ST_ACK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_s   = 4'd0;
        state_s = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_r == LAST_CNT) begin
          if (!we_r) begin
            rdbuf_s[{idx_r, 3'b000} +: 8] = i_sram_data;
          end else begin
            rdbuf_s = rdbuf_r;
          end
          state_s = ST_HOLD;
        end else begin
          cnt_s   = cnt_r + 4'd1;
          state_s = ST_STROBE;
        end
      end
      ST_HOLD: begin
        next_s = first_set(be_r & above_mask(idx_r));
        if (next_s[2]) begin
          idx_s   = next_s[1:0];
          state_s = ST_SETUP;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Pins are decoded from the next state so they register in step with it
    case (state_s)
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        cs_n_s = cs_decode(waddr_s[20:19]);
        addr_s = {waddr_s[18:0], idx_s};
        oe_s   = we_s;
        if (we_s) begin
          dout_s = wdata_s[{idx_s, 3'b000} +: 8];
        end else begin
          dout_s = 8'h00;
        end
        if (state_s == ST_STROBE) begin
          rd_n_s = we_s;
          wr_n_s = !we_s;
        end else begin
          rd_n_s = 1'b1;
          wr_n_s = 1'b1;
        end
      end
      ST_ACK: begin
        if (port_b_s) begin
          b_ack_s = 1'b1;
          if (!we_s) begin
            b_rdata_s = rdbuf_s;
          end else begin
            b_rdata_s = b_rdata_r;
          end
        end else begin
          a_ack_s = 1'b1;
          if (!we_s) begin
            a_rdata_s = rdbuf_s;
          end else begin
            a_rdata_s = a_rdata_r;
          end
        end
      end
      default: begin
        cs_n_s = 4'hF;
        oe_s   = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, transaction context and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      port_b_r   <= 1'b0;
      we_r       <= 1'b0;
      waddr_r    <= 21'h0;
      be_r       <= 4'h0;
      wdata_r    <= 32'h0;
      idx_r      <= 2'd0;
      cnt_r      <= 4'd0;
      rdbuf_r    <= 32'h0;
      favour_b_r <= 1'b0;
      cs_n_r     <= 4'hF;
      rd_n_r     <= 1'b1;
      wr_n_r     <= 1'b1;
      addr_r     <= 21'h0;
      dout_r     <= 8'h00;
      oe_r       <= 1'b0;
      a_ack_r    <= 1'b0;
      b_ack_r    <= 1'b0;
      a_rdata_r  <= 32'h0;
      b_rdata_r  <= 32'h0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      port_b_r   <= port_b_s;
      we_r       <= we_s;
      waddr_r    <= waddr_s;
      be_r       <= be_s;
      wdata_r    <= wdata_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      rdbuf_r    <= rdbuf_s;
      favour_b_r <= favour_b_s;
      cs_n_r     <= cs_n_s;
      rd_n_r     <= rd_n_s;
      wr_n_r     <= wr_n_s;
      addr_r     <= addr_s;
      dout_r     <= dout_s;
      oe_r       <= oe_s;
      a_ack_r    <= a_ack_s;
      b_ack_r    <= b_ack_s;
      a_rdata_r  <= a_rdata_s;
      b_rdata_r  <= b_rdata_s;
      busy_r     <= busy_s;
    end
  end

  assign o_sram_cs_n    = cs_n_r;
  assign o_sram_read_n  = rd_n_r;
  assign o_sram_write_n = wr_n_r;
  assign o_sram_addr    = addr_r;
  assign o_sram_data    = dout_r;
  assign o_sram_data_oe = oe_r;
  assign o_a_ack        = a_ack_r;
  assign o_b_ack        = b_ack_r;
  assign o_a_rdata      = a_rdata_r;
  assign o_b_rdata      = b_rdata_r;
  assign o_busy         = busy_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requests push expected acks and
// SRAM byte accesses; one monitor process pops and compares them.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [20:0] a_addr = 21'h0, b_addr = 21'h0;
  logic [3:0]  a_be = 4'h0, b_be = 4'h0;
  logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;
  logic        a_ack, b_ack, busy;
  logic [31:0] a_rdata, b_rdata;
  logic [3:0]  cs_n;
  logic        rd_n, wr_n, oe;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din = 8'h00;

  logic        fp_a_req = 1'b0, fp_b_req = 1'b0;
  logic        fp_a_ack, fp_b_ack, fp_rd_n, fp_wr_n, fp_oe, fp_busy;
  logic [31:0] fp_a_rdata, fp_b_rdata;
  logic [3:0]  fp_cs_n;
  logic [20:0] fp_addr;
  logic [7:0]  fp_dout;

  sram_arbiter #(.WAIT_CYCLES(W), .FIXED_PRIO_A(1'b0)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_be(a_be), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_be(b_be), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata),
    .o_sram_cs_n(cs_n), .o_sram_read_n(rd_n), .o_sram_write_n(wr_n), .o_sram_addr(sram_addr),
    .o_sram_data(sram_dout), .o_sram_data_oe(oe), .i_sram_data(sram_din), .o_busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(W), .FIXED_PRIO_A(1'b1)) u_dut_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(fp_a_req), .i_a_we(1'b0), .i_a_addr(21'h0), .i_a_be(4'h0), .i_a_wdata(32'h0),
    .o_a_ack(fp_a_ack), .o_a_rdata(fp_a_rdata),
    .i_b_req(fp_b_req), .i_b_we(1'b0), .i_b_addr(21'h0), .i_b_be(4'h0), .i_b_wdata(32'h0),
    .o_b_ack(fp_b_ack), .o_b_rdata(fp_b_rdata),
    .o_sram_cs_n(fp_cs_n), .o_sram_read_n(fp_rd_n), .o_sram_write_n(fp_wr_n), .o_sram_addr(fp_addr),
    .o_sram_data(fp_dout), .o_sram_data_oe(fp_oe), .i_sram_data(8'h00), .o_busy(fp_busy)
  );

  typedef struct packed {
    logic        port_b;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } exp_t;

  typedef struct packed {
    logic [3:0]  cs_n;
    logic [20:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Byte-wide SRAM bank model
  logic [7:0] mem [logic [22:0]];
  function automatic logic [1:0] chip_of(input logic [3:0] c);
    case (c)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [22:0] key;
    key = {chip_of(cs_n), sram_addr};
    if (!wr_n && cs_n != 4'hF) mem[key] = sram_dout;
    if (!rd_n && cs_n != 4'hF && mem.exists(key)) sram_din = mem[key];
    else sram_din = 8'h00;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: acks against exp_q, strobes against acc_q
  logic busy_q = 1'b0;
  logic in_strobe = 1'b0;
  int grant_cyc = 0;
  int slen = 0;
  always @(posedge clk) begin
    exp_t e;
    acc_t a;
    #1;
    if (!rst_n) begin
      busy_q = 1'b0;
      in_strobe = 1'b0;
      slen = 0;
    end else begin
      if (busy && !busy_q) grant_cyc = cyc;
      busy_q = busy;
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got a_ack=%0b b_ack=%0b, required none (t=%0t)", a_ack, b_ack, $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", {30'h0, a_ack, b_ack}, e.port_b ? 32'h1 : 32'h2);
          // the requester consumes the ack at the edge that closes its cycle
          check("ack_latency", 32'(cyc - grant_cyc + 1), {24'h0, e.lat});
          if (!e.we) check("rdata", e.port_b ? b_rdata : a_rdata, e.rdata);
          check("other_rdata_hold", e.port_b ? a_rdata : b_rdata, last_rd[!e.port_b]);
          check("ack_pins_quiet", {26'h0, cs_n, rd_n, wr_n}, {26'h0, 4'hF, 1'b1, 1'b1});
          check("ack_oe_off", {31'h0, oe}, 32'h0);
          if (!e.we) last_rd[e.port_b] = e.rdata;
        end
      end
      if (!rd_n || !wr_n) begin
        if (!in_strobe) begin
          if (acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got cs_n=%0h addr=%0h, required none (t=%0t)", cs_n, sram_addr, $time);
          end else begin
            a = acc_q.pop_front();
            check("strobe_cs_n", {28'h0, cs_n}, {28'h0, a.cs_n});
            check("strobe_addr", {11'h0, sram_addr}, {11'h0, a.addr});
            check("strobe_dir", {30'h0, ~wr_n, ~rd_n}, a.we ? 32'h2 : 32'h1);
            check("strobe_oe", {31'h0, oe}, {31'h0, a.we});
            if (a.we) check("strobe_wdata", {24'h0, sram_dout}, {24'h0, a.data});
          end
          in_strobe = 1'b1;
          slen = 1;
        end else begin
          slen++;
        end
      end else if (in_strobe) begin
        check("strobe_width", 32'(slen), 32'(W));
        in_strobe = 1'b0;
      end
      if (!rd_n) check("read_oe_overlap", {31'h0, oe}, 32'h0);
    end
  end

  task automatic wait_ack(input logic pb);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (pb ? b_ack : a_ack) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL ack_timeout: got no ack on port %0s within 200 cycles, required one", pb ? "B" : "A");
  endtask

  task automatic run_vec(input logic pb, input logic we, input logic [20:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic [3:0] exp_cs);
    exp_t e;
    acc_t a;
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        k++;
        a.cs_n = exp_cs;
        a.addr = {addr[18:0], 2'(i)};
        a.we   = we;
        a.data = wd[8*i +: 8];
        acc_q.push_back(a);
      end
    end
    e.port_b = pb;
    e.we     = we;
    e.rdata  = exp_rd;
    e.lat    = 8'(k * (W + 2) + 1);
    exp_q.push_back(e);
    @(negedge clk);
    if (pb) begin
      b_we = we; b_addr = addr; b_be = be; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_be = be; a_wdata = wd; a_req = 1'b1;
    end
    wait_ack(pb);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    acc_t a;
    int acks, fa, fb, found;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_cs_n", {28'h0, cs_n}, 32'hF);
    check("rst_strobes_oe", {29'h0, rd_n, wr_n, oe}, 32'h6);
    check("rst_addr_data", {3'h0, sram_addr, sram_dout}, 32'h0);
    check("rst_acks_busy", {29'h0, a_ack, b_ack, busy}, 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //      port  we    word addr    be       wdata         exp rdata     cs_n
    run_vec(1'b0, 1'b1, 21'h000010, 4'hF,    32'hA1B2C3D4, 32'h0,        4'hE);
    run_vec(1'b1, 1'b0, 21'h000010, 4'hF,    32'h0,        32'hA1B2C3D4, 4'hE);
    run_vec(1'b0, 1'b0, 21'h000010, 4'b0101, 32'h0,        32'h00B200D4, 4'hE);
    run_vec(1'b0, 1'b1, 21'h07FFFF, 4'hF,    32'h11223344, 32'h0,        4'hE);
    run_vec(1'b1, 1'b0, 21'h07FFFF, 4'hF,    32'h0,        32'h11223344, 4'hE);
    run_vec(1'b0, 1'b1, 21'h080000, 4'hF,    32'h55667788, 32'h0,        4'hD);
    run_vec(1'b1, 1'b0, 21'h080000, 4'b0011, 32'h0,        32'h00007788, 4'hD);
    run_vec(1'b0, 1'b1, 21'h1FFFFF, 4'b1000, 32'h99000000, 32'h0,        4'h7);
    run_vec(1'b1, 1'b0, 21'h1FFFFF, 4'hF,    32'h0,        32'h99000000, 4'h7);
    run_vec(1'b0, 1'b0, 21'h000010, 4'h0,    32'h0,        32'h0,        4'hE);
    run_vec(1'b1, 1'b1, 21'h000010, 4'h0,    32'h12345678, 32'h0,        4'hE);

    // Round-robin: B was served last, so A, B, A, B, A, B
    for (int r = 0; r < 3; r++) begin
      e.port_b = 1'b0; e.we = 1'b0; e.rdata = 32'h0; e.lat = 8'd1;
      exp_q.push_back(e);
      e.port_b = 1'b1; e.we = 1'b0; e.rdata = 32'h000000D4; e.lat = 8'd5;
      exp_q.push_back(e);
      a.cs_n = 4'hE; a.addr = 21'h000040; a.we = 1'b0; a.data = 8'h00;
      acc_q.push_back(a);
    end
    @(negedge clk);
    a_we = 1'b0; a_addr = 21'h0; a_be = 4'h0; a_req = 1'b1;
    b_we = 1'b0; b_addr = 21'h000010; b_be = 4'b0001; b_req = 1'b1;
    acks = 0;
    for (int n = 0; n < 200 && acks < 6; n++) begin
      @(posedge clk);
      #1;
      if (a_ack || b_ack) acks++;
    end
    check("rr_ack_count", 32'(acks), 32'd6);
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (3) @(negedge clk);

    // Fixed priority: A wins every re-request while B waits
    fp_a_req = 1'b1;
    fp_b_req = 1'b1;
    fa = 0;
    fb = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (fp_a_ack) fa++;
      if (fp_b_ack) fb++;
    end
    check("fp_a_acks", 32'(fa), 32'd10);
    check("fp_b_acks", 32'(fb), 32'd0);
    @(negedge clk);
    fp_a_req = 1'b0;
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (fp_b_ack) found = 1;
    end
    check("fp_b_served_after_a_drops", 32'(found), 32'd1);
    @(negedge clk);
    fp_b_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a write strobe
    a.cs_n = 4'hE; a.addr = 21'h000400; a.we = 1'b1; a.data = 8'hEF;
    acc_q.push_back(a);
    @(negedge clk);
    a_we = 1'b1; a_addr = 21'h000100; a_be = 4'hF; a_wdata = 32'hDEADBEEF; a_req = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(posedge clk);
      #1;
      if (!wr_n) found = 1;
    end
    check("midrst_strobe_seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", {28'h0, cs_n}, 32'hF);
    check("midrst_pins", {27'h0, wr_n, rd_n, oe, busy, a_ack}, 32'h18);
    check("midrst_addr_data", {3'h0, sram_addr, sram_dout}, 32'h0);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (10) @(negedge clk);
    check("post_rst_idle", {31'h0, busy}, 32'h0);

    run_vec(1'b1, 1'b0, 21'h000010, 4'hF, 32'h0, 32'hA1B2C3D4, 4'hE);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the external 2Mx8 asynchronous SRAM bank (4 chips, 8 MB total) between two 32-bit word requesters: port A (CPU bus bridge) and port B (Ethernet MAC DMA).
- Arbitrates between the ports, then splits each 32-bit access into byte-wide SRAM cycles, honouring byte enables.
- Generates CS/RD/WR strobe timing and returns read data and a one-cycle ack.
- Sits between the system bus and the top-level SRAM pins. The top level does the io_sram_data tristate from the split data ports.

Parameters:
- WAIT_CYCLES, 2, cycles each read_n/write_n strobe stays low per byte (legal range 1..15).
- FIXED_PRIO_A, 0, 1 = port A always wins ties; 0 = round-robin.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_a_req  input  1  port A request, held until ack
- i_a_we  input  1  port A write (1) / read (0)
- i_a_addr  input  21  port A word address (byte address bits [22:2])
- i_a_be  input  4  port A byte enables, bit n = byte n
- i_a_wdata  input  32  port A write data
- o_a_ack  output  1  port A completion pulse
- o_a_rdata  output  32  port A read data, valid with ack
- i_b_req, i_b_we, i_b_addr, i_b_be, i_b_wdata, o_b_ack, o_b_rdata: same as port A, for port B
- o_sram_cs_n  output  4  chip selects, one-hot active low
- o_sram_read_n  output  1  output enable to SRAM
- o_sram_write_n  output  1  write strobe to SRAM
- o_sram_addr  output  21  SRAM byte address within chip
- o_sram_data  output  8  write data to pad
- o_sram_data_oe  output  1  pad drive enable
- i_sram_data  input  8  read data from pad
- o_busy  output  1  transaction in progress

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous and active-low: i_reset_n low clears all state immediately.
- Reset values:
  - cs_n = 4'hF; read_n = 1; write_n = 1; addr = 0; data = 0; data_oe = 0.
  - Both acks = 0; both rdata = 0; busy = 0.
  - Round-robin pointer favours A first.
- All SRAM-side outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, ACK.
- IDLE:
  - Samples requests and latches the winner's we/addr/be/wdata.
  - The first enabled byte index is the lowest set be bit.
  - Goes to SETUP. If be = 0, goes straight to ACK with no SRAM activity.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, FIXED_PRIO_A = 1: A wins.
  - Both requesting, FIXED_PRIO_A = 0: the port not served last wins. The pointer updates on every grant.
- Byte address: {word_addr, byte_idx} is 23 bits.
  - cs_n = ~(1 << addr23[22:21]).
  - o_sram_addr = addr23[20:0].
  - Byte n maps to data bits [8n+7:8n] (little endian).
- SETUP (1 cycle):
  - Drives cs_n and addr; strobes stay high.
  - On a write, drives data and sets data_oe = 1.
- STROBE (WAIT_CYCLES cycles):
  - read_n or write_n is low.
  - On a read, i_sram_data is captured into the rdata byte at the final strobe cycle.
- HOLD (1 cycle):
  - Strobe high; cs, addr, data and oe held.
  - If another enabled byte remains, advance to it and go to SETUP; else go to ACK.
  - Disabled bytes are skipped entirely.
  - On a read, disabled bytes return 0.
- ACK (1 cycle):
  - Winner's ack = 1 and rdata is valid.
  - cs_n = F; data_oe = 0.
  - Returns to IDLE.
- Latency: grant + k × (WAIT_CYCLES + 2) + 1 cycles, where k = number of enabled bytes. For WAIT_CYCLES = 2 and be = F, ack comes 17 cycles after the IDLE grant edge.
- Turnaround:
  - The ACK and IDLE cycles give at least 2 cycles with data_oe = 0 and strobes high between transactions.
  - data_oe never overlaps read_n = 0.
- Request stability:
  - Requester inputs are ignored after they are latched.
  - Dropping req mid-transaction does not abort; ack is still pulsed.
- The non-winning port's ack stays 0; its rdata holds its last value.
- o_busy = 1 in every state except IDLE.
- Reset mid-operation: all outputs return to their reset values asynchronously and no ack is issued. After release, arbitration restarts from IDLE.

Test Plan:
- Reset: assert i_reset_n = 0 mid-strobe -> cs_n = F, write_n = 1, data_oe = 0, busy = 0 immediately. No ack after release until a new req.
- Port A write, addr 0x000010, be = F, wdata 0xA1B2C3D4, WAIT_CYCLES = 2:
  - 4 byte cycles at sram addr 0x40..0x43 with cs_n = E.
  - Data sequence D4, C3, B2, A1.
  - write_n low 2 cycles each; o_a_ack 17 cycles after grant.
- Port B read of the same word with an SRAM model -> o_b_rdata = 0xA1B2C3D4 with o_b_ack. read_n is never low while data_oe = 1.
- Partial access, be = 4'b0101, read -> only sram addr offsets 0 and 2 accessed, rdata = 0x00B200D4, ack after 2 × 4 + 1 cycles.
- Chip-select boundary:
  - Word addr 0x07FFFF -> cs_n = E, sram addr 0x1FFFFC..0x1FFFFF.
  - Word addr 0x080000 -> cs_n = D, sram addr 0x000000.
  - Word addr 0x1FFFFF -> cs_n = 7.
- Contention, FIXED_PRIO_A = 0, both requesting continuously -> grants alternate A, B, A, B.
  - With FIXED_PRIO_A = 1 -> A served on every re-request and B waits.
  - be = 0 request -> ack 2 cycles after request, no strobes.
